// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one fifo write port.
// Ports: clock/resetn, req_valid/req_data/req_ready, fifo_full, fifo_wr_en/fifo_data_in, grant_id/busy.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_MAX  = 4
) (
  input  logic                          clock,
  input  logic                          resetn,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [IW-1:0] r_owner;
  logic [IW-1:0] w_owner_nxt;
  logic [IW-1:0] r_last;
  logic [IW-1:0] w_last_nxt;
  logic [BW-1:0] r_beat;
  logic [BW-1:0] w_beat_nxt;
  logic [IW-1:0] w_pick;
  logic [IW-1:0] w_idx;
  logic          w_found;
  logic          w_act;
  logic          w_own_vld;
  logic          w_wr;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_last  <= IW'(NUM_REQ - 1);
      r_beat  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_last  <= w_last_nxt;
      r_beat  <= w_beat_nxt;
    end
  end

  // Search starts just after the previous owner so every
  // requester is reached within NUM_REQ grants.
  always_comb begin
    w_pick  = '0;
    w_idx   = '0;
    w_found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = IW'((int'(r_last) + k) % NUM_REQ);
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_owner_nxt  = r_owner;
    w_last_nxt   = r_last;
    w_beat_nxt   = r_beat;
    req_ready    = '0;
    fifo_data_in = '0;
    // resetn gating keeps the reset cycle write-free
    w_act        = (r_state == GRANT) && resetn;
    w_own_vld    = req_valid[r_owner];
    w_wr         = w_act && w_own_vld && !fifo_full;
    fifo_wr_en   = w_wr;
    if (w_act) begin
      req_ready[r_owner] = !fifo_full;
    end
    if (w_wr) begin
      fifo_data_in =
        req_data[int'(r_owner)*DATA_WIDTH +: DATA_WIDTH];
    end
    unique case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt = GRANT;
          w_owner_nxt = w_pick;
          w_beat_nxt  = '0;
        end
      end
      GRANT: begin
        if (w_wr) begin
          w_beat_nxt = r_beat + BW'(1);
        end
        if (!w_own_vld ||
            (w_wr && r_beat == BW'(BURST_MAX - 1))) begin
          w_state_nxt = IDLE;
          w_last_nxt  = r_owner;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign grant_id = r_owner;
  assign busy     = (r_state == GRANT);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: randomized and directed checks of fifo_wr_arbiter
// against a transaction-level round-robin model with producer and fifo queues.
module tb_fifo_wr_arbiter;

  localparam int N     = 4;
  localparam int W     = 32;
  localparam int B     = 4;
  localparam int DEPTH = 256;

  logic         clock = 1'b0;
  logic         resetn;
  logic [N-1:0] req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0] req_ready;
  logic         fifo_full;
  logic         fifo_wr_en;
  logic [W-1:0] fifo_data_in;
  logic [1:0]   grant_id;
  logic         busy;

  fifo_wr_arbiter #(
    .NUM_REQ(N), .DATA_WIDTH(W), .BURST_MAX(B)
  ) dut (
    .clock(clock), .resetn(resetn),
    .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_full(fifo_full),
    .fifo_wr_en(fifo_wr_en), .fifo_data_in(fifo_data_in),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] q [N][$];
  logic [W-1:0] fq[$];
  int           gid_log[$];
  logic         wr_seq[$];
  logic [N-1:0] en;
  logic         full_force;
  bit           use_fifo;
  bit           prev_busy;

  bit m_busy;
  int m_owner, m_last, m_beats;

  string        o_str, e_str;
  logic         o_wr, o_busy;
  logic [N-1:0] o_rdy;
  logic [1:0]   o_gid;

  function automatic logic [W-1:0] tag(int r, int n);
    return {8'(r), 24'(n)};
  endfunction

  task automatic model_reset();
    m_busy  = 1'b0;
    m_owner = 0;
    m_last  = N - 1;
    m_beats = 0;
  endtask

  // One clock: drive inputs, sample outputs, predict, advance model.
  task automatic cycle();
    logic [N-1:0] e_rdy;
    logic         e_wr;
    logic [W-1:0] e_data;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = en[i] && q[i].size() > 0;
      req_data[i*W +: W] = (q[i].size() > 0) ? q[i][0] : '0;
    end
    fifo_full = use_fifo ? (fq.size() >= DEPTH) : full_force;
    #1;
    o_wr  = fifo_wr_en;
    o_rdy = req_ready;
    o_busy = busy;
    o_gid = grant_id;
    e_rdy = '0;
    e_wr  = 1'b0;
    e_data = '0;
    if (resetn && m_busy) begin
      e_rdy = fifo_full ? '0 : (4'(1) << m_owner);
      e_wr  = req_valid[m_owner] && !fifo_full;
      if (e_wr) e_data = q[m_owner][0];
    end
    o_str = $sformatf("rdy=%b wr=%b d=%h busy=%b gid=%0d",
      req_ready, fifo_wr_en, fifo_data_in, busy,
      m_busy ? grant_id : 2'd0);
    e_str = $sformatf("rdy=%b wr=%b d=%h busy=%b gid=%0d",
      e_rdy, e_wr, e_data, m_busy, m_busy ? 2'(m_owner) : 2'd0);
    wr_seq.push_back(o_wr);
    if (o_busy && !prev_busy) gid_log.push_back(int'(o_gid));
    prev_busy = o_busy;
    for (int i = 0; i < N; i++)
      if (req_valid[i] && req_ready[i]) void'(q[i].pop_front());
    if (o_wr) fq.push_back(fifo_data_in);
    if (!resetn) begin
      model_reset();
    end else if (!m_busy) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (!m_busy && req_valid[c]) begin
          m_owner = c;
          m_busy  = 1'b1;
          m_beats = 0;
        end
      end
    end else begin
      if (e_wr) m_beats++;
      if (!req_valid[m_owner] || m_beats == B) begin
        m_busy = 1'b0;
        m_last = m_owner;
      end
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic clear_all();
    for (int i = 0; i < N; i++) q[i].delete();
    fq.delete();
    gid_log.delete();
    wr_seq.delete();
    en = '0;
    full_force = 1'b0;
    use_fifo = 1'b0;
  endtask

  task automatic do_reset();
    clear_all();
    resetn = 1'b0;
    cycle();
    resetn = 1'b1;
    clear_all();
  endtask

  task automatic test_reset();
    clear_all();
    for (int i = 0; i < N; i++) q[i].push_back(tag(i, 0));
    en = '1;
    resetn = 1'b0;
    for (int c = 0; c < 3; c++) begin
      cycle();
      checks++;
      if (o_str != e_str || o_gid !== 2'd0) begin
        errors++;
        $display("FAIL reset c%0d got %s gid=%0d exp %s gid=0",
          c, o_str, o_gid, e_str);
      end
    end
    resetn = 1'b1;
    clear_all();
  endtask

  task automatic test_single();
    logic [7:0] seq;
    do_reset();
    for (int k = 0; k < 6; k++) q[0].push_back(tag(0, k));
    en = 4'b0001;
    for (int c = 0; c < 10; c++) begin
      cycle();
      checks++;
      if (o_str != e_str) begin
        errors++;
        $display("FAIL single c%0d got %s exp %s", c, o_str, e_str);
      end
    end
    seq = '0;
    for (int k = 0; k < 8; k++) seq[7-k] = wr_seq[k];
    checks++;
    if (seq !== 8'b0111_1011) begin
      errors++;
      $display("FAIL single_pattern got %b exp 01111011", seq);
    end
    checks++;
    if (fq.size() != 6) begin
      errors++;
      $display("FAIL single_count got %0d exp 6", fq.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (fq[k] !== tag(0, k)) begin
          errors++;
          $display("FAIL single_data %0d got %h exp %h",
            k, fq[k], tag(0, k));
        end
      end
    end
  endtask

  task automatic test_all4();
    do_reset();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 2; k++) q[i].push_back(tag(i, k));
    en = 4'b1111;
    for (int c = 0; c < 20; c++) begin
      cycle();
      checks++;
      if (o_str != e_str) begin
        errors++;
        $display("FAIL all4 c%0d got %s exp %s", c, o_str, e_str);
      end
    end
    checks++;
    if (gid_log.size() != 4 || fq.size() != 8) begin
      errors++;
      $display("FAIL all4_counts got grants=%0d writes=%0d exp 4 8",
        gid_log.size(), fq.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (gid_log[k] != k) begin
          errors++;
          $display("FAIL all4_order %0d got %0d exp %0d",
            k, gid_log[k], k);
        end
      end
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (fq[k] !== tag(k / 2, k % 2)) begin
          errors++;
          $display("FAIL all4_pop %0d got %h exp %h",
            k, fq[k], tag(k / 2, k % 2));
        end
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    for (int k = 0; k < 4; k++) q[1].push_back(tag(1, k));
    en = 4'b0010;
    for (int c = 0; c < 11; c++) begin
      full_force = (c >= 2 && c <= 4);
      cycle();
      checks++;
      if (o_str != e_str) begin
        errors++;
        $display("FAIL stall c%0d got %s exp %s", c, o_str, e_str);
      end
      if (c >= 2 && c <= 4) begin
        checks++;
        if (o_wr !== 1'b0 || o_rdy[1] !== 1'b0) begin
          errors++;
          $display("FAIL stall_full c%0d got wr=%b rdy1=%b exp 0 0",
            c, o_wr, o_rdy[1]);
        end
      end
    end
    checks++;
    if (gid_log.size() != 1 || fq.size() != 4) begin
      errors++;
      $display("FAIL stall_burst got grants=%0d writes=%0d exp 1 4",
        gid_log.size(), fq.size());
    end
  endtask

  task automatic test_drop();
    do_reset();
    q[2].push_back(tag(2, 0));
    q[3].push_back(tag(3, 0));
    q[3].push_back(tag(3, 1));
    en = 4'b1100;
    for (int c = 0; c < 9; c++) begin
      cycle();
      checks++;
      if (o_str != e_str) begin
        errors++;
        $display("FAIL drop c%0d got %s exp %s", c, o_str, e_str);
      end
    end
    checks++;
    if (gid_log.size() != 2) begin
      errors++;
      $display("FAIL drop_grants got %0d exp 2", gid_log.size());
    end else if (gid_log[0] != 2 || gid_log[1] != 3) begin
      errors++;
      $display("FAIL drop_order got %0d,%0d exp 2,3",
        gid_log[0], gid_log[1]);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    q[0].push_back(tag(0, 0));
    for (int k = 0; k < 6; k++) q[1].push_back(tag(1, k));
    en = 4'b0011;
    for (int c = 0; c < 10; c++) begin
      resetn = (c != 5);
      if (c == 5) q[0].push_back(tag(0, 1));
      cycle();
      checks++;
      if (o_str != e_str) begin
        errors++;
        $display("FAIL rstmid c%0d got %s exp %s", c, o_str, e_str);
      end
      if (c == 5) begin
        checks++;
        if (o_wr !== 1'b0) begin
          errors++;
          $display("FAIL rstmid_wr got %b exp 0", o_wr);
        end
      end
      if (c == 6) begin
        checks++;
        if (o_busy !== 1'b0 || o_wr !== 1'b0) begin
          errors++;
          $display("FAIL rstmid_idle got busy=%b wr=%b exp 0 0",
            o_busy, o_wr);
        end
      end
    end
    checks++;
    if (gid_log.size() != 3 || gid_log[2] != 0) begin
      errors++;
      $display("FAIL rstmid_regrant got n=%0d last=%0d exp 3 0",
        gid_log.size(), gid_log.size() > 0 ? gid_log[$] : -1);
    end
  endtask

  task automatic test_fill();
    int cnt[N];
    int bad;
    int extra;
    int left;
    do_reset();
    use_fifo = 1'b1;
    for (int i = 0; i < N; i++) begin
      cnt[i] = 0;
      for (int k = 0; k < 80; k++) q[i].push_back(tag(i, k));
    end
    bad = 0;
    extra = 0;
    for (int c = 0; c < 3000 && extra < 12; c++) begin
      en = 4'($urandom);
      cycle();
      checks++;
      if (o_str != e_str) begin
        errors++;
        $display("FAIL fill c%0d got %s exp %s", c, o_str, e_str);
      end
      if (o_wr && fifo_full) bad++;
      if (fq.size() >= DEPTH) extra++;
    end
    checks++;
    if (bad != 0 || fq.size() != DEPTH) begin
      errors++;
      $display("FAIL fill_full got overwr=%0d words=%0d exp 0 %0d",
        bad, fq.size(), DEPTH);
    end
    bad = 0;
    foreach (fq[k]) begin
      int r;
      r = int'(fq[k][31:24]);
      if (r >= N) bad++;
      else begin
        if (fq[k][23:0] != 24'(cnt[r])) bad++;
        cnt[r]++;
      end
    end
    left = 0;
    for (int i = 0; i < N; i++) left += q[i].size();
    checks++;
    if (bad != 0 || left != N * 80 - DEPTH) begin
      errors++;
      $display("FAIL fill_order got bad=%0d left=%0d exp 0 %0d",
        bad, left, N * 80 - DEPTH);
    end
    use_fifo = 1'b0;
  endtask

  initial begin
    resetn = 1'b0;
    req_valid = '0;
    req_data = '0;
    fifo_full = 1'b0;
    prev_busy = 1'b0;
    clear_all();
    model_reset();
    @(posedge clock);
    @(negedge clock);
    test_reset();
    test_single();
    test_all4();
    test_stall();
    test_drop();
    test_reset_mid();
    test_fill();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
